// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD zoom controller: command codes, FSM states,
// display modes and a width helper for counters.
package lcd_pkg;

  typedef enum logic [2:0] {
    CMD_LOAD     = 3'd0,
    CMD_ZOOM_IN  = 3'd1,
    CMD_ZOOM_FIT = 3'd2,
    CMD_SHIFT_R  = 3'd3,
    CMD_SHIFT_L  = 3'd4,
    CMD_SHIFT_U  = 3'd5,
    CMD_SHIFT_D  = 3'd6,
    CMD_MIRROR   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_EXEC,
    ST_OUT
  } state_e;

  typedef enum logic {
    MODE_FIT,
    MODE_ZOOM
  } mode_e;

  // Bits needed to hold values 0..n-1; a one-value range still gets one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_img_buf.sv
// Image frame store: one write port (synchronous), one combinational read port.
module lcd_img_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 108,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  // NOTE: the frame store has no reset; contents survive a reset so a partly
  // loaded frame keeps whatever pixels were already written.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lcd_zoom_ctrl.sv
// LCD zoom controller: loads a frame, then emits a WIN x WIN window either as a
// decimated full view (FIT) or a 1:1 movable crop (ZOOM), optionally mirrored.
module lcd_zoom_ctrl
  import lcd_pkg::*;
#(
  parameter int DW    = 8,
  parameter int IMG_H = 9,
  parameter int IMG_W = 12,
  parameter int WIN   = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [2:0]    cmd,
  input  logic          cmd_valid,
  input  logic [DW-1:0] datain,
  output logic          busy,
  output logic [DW-1:0] dataout,
  output logic          output_valid,
  input  logic          output_ready
);

  localparam int NPIX    = IMG_H * IMG_W;
  localparam int AW      = cw(NPIX);
  localparam int WW      = cw(WIN);
  localparam int RW      = cw(IMG_H - WIN + 1);
  localparam int CW      = cw(IMG_W - WIN + 1);
  localparam int RS      = IMG_H / WIN;
  localparam int CS      = IMG_W / WIN;
  localparam int ROW_MAX = IMG_H - WIN;
  localparam int COL_MAX = IMG_W - WIN;
  localparam int ORG_R   = IMG_H / 2 - WIN / 2;
  localparam int ORG_C   = IMG_W / 2 - WIN / 2;

  if (WIN < 1 || WIN > IMG_H || WIN > IMG_W) begin : g_bad_win
    $error("lcd_zoom_ctrl: WIN must satisfy 1 <= WIN <= IMG_H and WIN <= IMG_W");
  end

  state_e        r_state, w_state_nxt;
  cmd_e          r_cmd;
  mode_e         r_mode;
  logic          r_mirror;
  logic [RW-1:0] r_orow;
  logic [CW-1:0] r_ocol;
  logic [AW-1:0] r_ld_cnt;
  logic [WW-1:0] r_oi, r_oj;

  logic          w_ld_last, w_out_fire, w_out_last;
  logic [WW-1:0] w_col_idx;
  logic [AW-1:0] w_row, w_col, w_rd_addr;
  logic [DW-1:0] w_rd_data;

  assign w_ld_last  = (r_ld_cnt == AW'(NPIX - 1));
  assign w_out_fire = output_valid && output_ready;
  assign w_out_last = (r_oi == WW'(WIN - 1)) && (r_oj == WW'(WIN - 1));

  // Mirror swaps window columns; FIT samples the centre of each RS x CS cell.
  assign w_col_idx = r_mirror ? (WW'(WIN - 1) - r_oj) : r_oj;
  assign w_row     = (r_mode == MODE_ZOOM) ? (AW'(r_orow) + AW'(r_oi))
                                           : (AW'(RS / 2) + AW'(r_oi) * AW'(RS));
  assign w_col     = (r_mode == MODE_ZOOM) ? (AW'(r_ocol) + AW'(w_col_idx))
                                           : (AW'(CS / 2) + AW'(w_col_idx) * AW'(CS));
  assign w_rd_addr = w_row * AW'(IMG_W) + w_col;

  lcd_img_buf #(
    .DW    (DW),
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_img_buf (
    .clk     (clk),
    .i_we    (r_state == ST_LOAD),
    .i_waddr (r_ld_cnt),
    .i_wdata (datain),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  assign busy         = (r_state != ST_IDLE);
  assign output_valid = (r_state == ST_OUT);
  assign dataout      = output_valid ? w_rd_data : '0;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: the default at the top keeps every path assigned, so no latch forms.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (cmd_valid) w_state_nxt = (cmd == CMD_LOAD) ? ST_LOAD : ST_EXEC;
      ST_LOAD: if (w_ld_last) w_state_nxt = ST_OUT;
      ST_EXEC: w_state_nxt = ST_OUT;
      ST_OUT:  if (w_out_fire && w_out_last) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd    <= CMD_LOAD;
      r_mode   <= MODE_FIT;
      r_mirror <= 1'b0;
      r_orow   <= RW'(ORG_R);
      r_ocol   <= CW'(ORG_C);
      r_ld_cnt <= '0;
      r_oi     <= '0;
      r_oj     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: if (cmd_valid) r_cmd <= cmd_e'(cmd);
        ST_LOAD: begin
          if (w_ld_last) begin
            r_ld_cnt <= '0;
            r_mode   <= MODE_FIT;
            r_mirror <= 1'b0;
            r_orow   <= RW'(ORG_R);
            r_ocol   <= CW'(ORG_C);
          end else begin
            r_ld_cnt <= r_ld_cnt + AW'(1);
          end
        end
        ST_EXEC: begin
          // Shifts only move the crop in ZOOM and stop dead at the frame edge.
          unique case (r_cmd)
            CMD_ZOOM_IN: if (r_mode == MODE_FIT) begin
              r_mode <= MODE_ZOOM;
              r_orow <= RW'(ORG_R);
              r_ocol <= CW'(ORG_C);
            end
            CMD_ZOOM_FIT: r_mode <= MODE_FIT;
            CMD_SHIFT_R: if (r_mode == MODE_ZOOM && r_ocol != CW'(COL_MAX)) r_ocol <= r_ocol + CW'(1);
            CMD_SHIFT_L: if (r_mode == MODE_ZOOM && r_ocol != '0)           r_ocol <= r_ocol - CW'(1);
            CMD_SHIFT_U: if (r_mode == MODE_ZOOM && r_orow != '0)           r_orow <= r_orow - RW'(1);
            CMD_SHIFT_D: if (r_mode == MODE_ZOOM && r_orow != RW'(ROW_MAX)) r_orow <= r_orow + RW'(1);
            CMD_MIRROR:  r_mirror <= ~r_mirror;
            default: ;
          endcase
        end
        ST_OUT: begin
          if (w_out_fire) begin
            if (r_oj == WW'(WIN - 1)) begin
              r_oj <= '0;
              r_oi <= (r_oi == WW'(WIN - 1)) ? '0 : r_oi + WW'(1);
            end else begin
              r_oj <= r_oj + WW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_zoom_ctrl.sv
// Directed self-checking bench for lcd_zoom_ctrl with default parameters
// (img[r][c] = 12r + c after a ramp load).
module tb_lcd_zoom_ctrl;
  import lcd_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [2:0]    cmd;
  logic          cmd_valid;
  logic [DW-1:0] datain;
  logic          busy;
  logic [DW-1:0] dataout;
  logic          output_valid;
  logic          output_ready;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] got [16];

  logic [DW-1:0] e_fit   [16] = '{13, 16, 19, 22, 37, 40, 43, 46, 61, 64, 67, 70, 85, 88, 91, 94};
  logic [DW-1:0] e_fitm  [16] = '{22, 19, 16, 13, 46, 43, 40, 37, 70, 67, 64, 61, 94, 91, 88, 85};
  logic [DW-1:0] e_zoom  [16] = '{28, 29, 30, 31, 40, 41, 42, 43, 52, 53, 54, 55, 64, 65, 66, 67};
  logic [DW-1:0] e_mir   [16] = '{31, 30, 29, 28, 43, 42, 41, 40, 55, 54, 53, 52, 67, 66, 65, 64};
  logic [DW-1:0] e_final [16] = '{8, 9, 10, 11, 20, 21, 22, 23, 32, 33, 34, 35, 44, 45, 46, 47};
  logic [DW-1:0] e_abort [16] = '{113, 116, 119, 122, 137, 140, 143, 146, 61, 64, 67, 70, 85, 88, 91, 94};
  int            e_r     [10] = '{29, 30, 31, 32, 32, 32, 32, 32, 32, 32};
  int            e_u     [5]  = '{20, 8, 8, 8, 8};

  always #5 clk = ~clk;

  lcd_zoom_ctrl #(.DW(DW), .IMG_H(9), .IMG_W(12), .WIN(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .datain       (datain),
    .busy         (busy),
    .dataout      (dataout),
    .output_valid (output_valid),
    .output_ready (output_ready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Non-LOAD command: accept, then one EXEC cycle with no valid output.
  task automatic issue(input logic [2:0] c);
    @(negedge clk);
    check("idle_before_cmd", busy, 0);
    cmd = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    check("no_valid_in_exec", output_valid, 0);
  endtask

  // LOAD ramp datain = k + offset; abort_at >= 0 pulls reset while driving that pixel.
  task automatic load(input int offset, input int abort_at);
    @(negedge clk);
    cmd = CMD_LOAD;
    cmd_valid = 1'b1;
    for (int k = 0; k < 108; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", output_valid, 0);
        check("abort_dataout", dataout, 0);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (k == 0)  check("load_busy", busy, 1);
      if (k == 60) check("load_no_valid", output_valid, 0);
      datain = DW'(k + offset);
    end
  endtask

  // Drain one 16-pixel burst into got[], optionally stalling at pixel stall_px.
  task automatic run_out(input string tag, input int stall_px, input int stall_len, input bit poke);
    int n = 0;
    int cyc = 0;
    int st = 0;
    logic [DW-1:0] held = '0;
    output_ready = 1'b1;
    while (n < 16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_first_valid"}, output_valid, 1);
      if (output_valid) begin
        if (n == stall_px && st < stall_len) begin
          if (st == 0) held = dataout;
          else         check({tag, "_hold"}, dataout, held);
          output_ready = 1'b0;
          cmd = CMD_ZOOM_FIT;
          cmd_valid = poke && (st == 1);
          st++;
        end else begin
          if (st > 0 && n == stall_px) check({tag, "_hold"}, dataout, held);
          output_ready = 1'b1;
          cmd_valid = 1'b0;
          got[n] = dataout;
          n++;
        end
      end
    end
    check({tag, "_count"}, n, 16);
    @(negedge clk);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_valid_end"}, output_valid, 0);
  endtask

  task automatic cmp_win(input string tag, input logic [DW-1:0] e [16]);
    for (int i = 0; i < 16; i++) check($sformatf("%s_px%0d", tag, i), got[i], e[i]);
  endtask

  initial begin
    reset_n = 1'b0;
    cmd = 3'd0;
    cmd_valid = 1'b0;
    datain = '0;
    output_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", output_valid, 0);
    check("rst_dataout", dataout, 0);
    reset_n = 1'b1;

    load(0, -1);
    run_out("load", -1, 0, 1'b0);
    cmp_win("load", e_fit);

    issue(CMD_SHIFT_R); run_out("fit_shift", -1, 0, 1'b0); cmp_win("fit_shift", e_fit);
    issue(CMD_ZOOM_IN); run_out("zoom", -1, 0, 1'b0);      cmp_win("zoom", e_zoom);
    issue(CMD_ZOOM_IN); run_out("zoom2", -1, 0, 1'b0);     cmp_win("zoom2", e_zoom);
    issue(CMD_MIRROR);  run_out("mir", -1, 0, 1'b0);       cmp_win("mir", e_mir);
    issue(CMD_MIRROR);  run_out("unmir", -1, 0, 1'b0);     cmp_win("unmir", e_zoom);

    for (int r = 0; r < 10; r++) begin
      issue(CMD_SHIFT_R);
      run_out($sformatf("shr%0d", r), -1, 0, 1'b0);
      check($sformatf("shr%0d_first", r), got[0], e_r[r]);
      check($sformatf("shr%0d_last", r), got[15], e_r[r] + 39);
    end
    for (int u = 0; u < 5; u++) begin
      issue(CMD_SHIFT_U);
      run_out($sformatf("shu%0d", u), -1, 0, 1'b0);
      check($sformatf("shu%0d_first", u), got[0], e_u[u]);
    end
    cmp_win("corner", e_final);

    issue(CMD_SHIFT_D); run_out("shd", -1, 0, 1'b0); check("shd_first", got[0], 20);
    issue(CMD_SHIFT_L); run_out("shl", -1, 0, 1'b0); check("shl_first", got[0], 19);
    issue(CMD_SHIFT_U); run_out("shu", -1, 0, 1'b0); check("shu_first", got[0], 7);
    issue(CMD_SHIFT_R); run_out("shr", -1, 0, 1'b0); check("shr_first", got[0], 8);

    issue(CMD_ZOOM_IN); run_out("stall", 5, 3, 1'b1);     cmp_win("stall", e_final);
    issue(CMD_ZOOM_IN); run_out("post_poke", -1, 0, 1'b0); cmp_win("post_poke", e_final);

    issue(CMD_ZOOM_FIT); run_out("fit", -1, 0, 1'b0);     cmp_win("fit", e_fit);
    issue(CMD_ZOOM_IN);  run_out("rezoom", -1, 0, 1'b0);  cmp_win("rezoom", e_zoom);
    issue(CMD_ZOOM_FIT); run_out("fit2", -1, 0, 1'b0);    cmp_win("fit2", e_fit);
    issue(CMD_MIRROR);   run_out("fit_mir", -1, 0, 1'b0); cmp_win("fit_mir", e_fitm);

    load(100, 50);
    @(negedge clk);
    check("post_abort_busy", busy, 0);
    issue(CMD_ZOOM_FIT); run_out("abort_fit", -1, 0, 1'b0); cmp_win("abort_fit", e_abort);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_zoom_ctrl.md
LCD_ZOOM_CTRL -- requirements
Module: lcd_zoom_ctrl

Interface
REQ-001 Parameter DW, 8, pixel data width.
REQ-002 Parameter IMG_H, 9, image rows.
REQ-003 Parameter IMG_W, 12, image columns.
REQ-004 Parameter WIN, 4, output window edge; WIN divides neither requirement, but WIN <= IMG_H and WIN <= IMG_W SHALL hold (elaboration error otherwise).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 cmd  input  3  command code (0 LOAD, 1 ZOOM_IN, 2 ZOOM_FIT, 3 SHIFT_R, 4 SHIFT_L, 5 SHIFT_U, 6 SHIFT_D, 7 MIRROR).
REQ-008 cmd_valid  input  1  command strobe.
REQ-009 datain  input  DW  pixel input during LOAD, one per cycle, row-major.
REQ-010 busy  output  1  command in progress; new commands ignored.
REQ-011 dataout  output  DW  output pixel.
REQ-012 output_valid  output  1  dataout valid.
REQ-013 output_ready  input  1  sink accepts dataout when high with output_valid.

Function
REQ-014 Command SHALL be accepted on a cycle with cmd_valid=1 and busy=0; busy=1 from the next cycle; cmd_valid while busy=1 SHALL be ignored.
REQ-015 Every command SHALL end with a WIN*WIN-pixel output burst, row-major; busy SHALL fall the cycle after the last pixel handshake.
REQ-016 FSM states: IDLE, LOAD, EXEC, OUT; IDLE->LOAD (cmd 0) or EXEC (others); LOAD->OUT after final pixel; EXEC->OUT after one cycle; OUT->IDLE after last handshake.
REQ-017 LOAD: pixel k (0..IMG_H*IMG_W-1) sampled on acceptance+1+k into row k/IMG_W, col k%IMG_W; afterwards mode=FIT, mirror=0, origin reset to REQ-020 value.
REQ-018 First output_valid SHALL be 2 cycles after acceptance for non-LOAD commands, 1 cycle after the last LOAD sample for LOAD.
REQ-019 FIT output: pixel (i,j) = img[RS/2 + i*RS][CS/2 + j*CS], RS=IMG_H/WIN, CS=IMG_W/WIN (integer division).
REQ-020 ZOOM_IN from FIT: mode=ZOOM, origin=(IMG_H/2-WIN/2, IMG_W/2-WIN/2); from ZOOM: origin unchanged, window re-output.
REQ-021 ZOOM output: pixel (i,j) = img[orow+i][ocol+j].
REQ-022 SHIFT in ZOOM: origin moves one pixel (R: ocol+1, L: ocol-1, U: orow-1, D: orow+1) clamped to orow in [0,IMG_H-WIN], ocol in [0,IMG_W-WIN]; at the bound origin holds and window is re-output.
REQ-023 SHIFT in FIT: no state change, FIT image re-output.
REQ-024 ZOOM_FIT: mode=FIT, origin retained for a later ZOOM_IN? No -- origin reset per REQ-020 on next ZOOM_IN from FIT.
REQ-025 MIRROR: toggles mirror flag; when set, column index j SHALL be replaced by WIN-1-j in both modes; window re-output.
REQ-026 output_valid=1 with output_ready=0: dataout and output_valid SHALL hold unchanged, no pixel dropped or repeated.
REQ-027 output_valid SHALL be 0 outside OUT.

Reset
REQ-028 reset_n=0 SHALL immediately force busy=0, output_valid=0, dataout=0, state IDLE, mode FIT, mirror=0, origin per REQ-020, all counters 0; image memory not reset.
REQ-029 Reset mid-LOAD or mid-OUT SHALL abort the command; partially loaded pixels remain in memory.

Structure
REQ-030 Shared package lcd_pkg SHALL hold command codes, FSM state and mode enumerations.
REQ-031 Image storage SHALL be sub-module lcd_img_buf: IMG_H*IMG_W x DW, synchronous write, combinational read, no reset.
REQ-032 Counter widths SHALL be $clog2 of their ranges; no truncation on origin clamp arithmetic.

Verification (defaults, datain = k, so img[r][c]=12r+c)
REQ-033 LOAD ramp 0..107 -> 16 outputs 13,16,19,22,37,40,43,46,61,64,67,70,85,88,91,94; busy low after last.
REQ-034 ZOOM_IN -> 28,29,30,31,40,41,42,43,52,53,54,55,64,65,66,67.
REQ-035 ZOOM_IN, 10x SHIFT_R, 5x SHIFT_U -> final window first row 8,9,10,11, last row 44..47; clamped commands still emit 16 pixels.
REQ-036 ZOOM_IN then MIRROR -> first row 31,30,29,28; second MIRROR restores 28,29,30,31.
REQ-037 output_ready low 3 cycles at pixel 5, cmd_valid pulsed while busy -> dataout frozen at pixel 5, all 16 pixels delivered once, pulsed cmd ignored.
REQ-038 reset_n low at LOAD pixel 50 -> busy=0, output_valid=0 next edge; new ZOOM_FIT outputs fit window with pixels 0..49 from ramp.
